// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster constants and sync-window helpers for vga_timing_gen.
package vga_timing_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int unsigned DEF_CW       = 11;

  // First position inside the sync pulse.
  function automatic int unsigned sync_start(input int unsigned active, input int unsigned fp);
    return active + fp;
  endfunction

  // First position after the sync pulse (exclusive bound).
  function automatic int unsigned sync_end(input int unsigned active, input int unsigned fp,
                                           input int unsigned sync);
    return active + fp + sync;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: next count, wrap and decoded active/sync levels for the next position.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned FP     = DEF_H_FP,
  parameter int unsigned SYNC   = DEF_H_SYNC,
  parameter int unsigned BP     = DEF_H_BP,
  parameter bit          POL    = 1'b0,
  parameter int unsigned CW     = DEF_CW
) (
  input  logic [CW-1:0] count,
  input  logic          advance,
  input  logic          restart,
  output logic [CW-1:0] next_c,
  output logic          wrap_c,
  output logic          active_c,
  output logic          sync_c
);

  localparam int unsigned TOTAL      = ACTIVE + FP + SYNC + BP;
  localparam int unsigned SYNC_START = sync_start(ACTIVE, FP);
  localparam int unsigned SYNC_END   = sync_end(ACTIVE, FP, SYNC);

  // Reject unusable geometry at elaboration time.
  if (ACTIVE == 0 || FP == 0 || SYNC == 0 || BP == 0) begin : g_zero_field
    $fatal(1, "vga_axis_counter: zero-width timing field");
  end
  if (((TOTAL - 1) >> CW) != 0) begin : g_cw_small
    $fatal(1, "vga_axis_counter: CW too small for total");
  end

  // Restart beats wrap beats increment; decode is taken from the next count.
  always_comb begin
    wrap_c = advance && (count == CW'(TOTAL - 1));
    next_c = count;
    if (restart) begin
      next_c = '0;
    end else if (wrap_c) begin
      next_c = '0;
    end else if (advance) begin
      next_c = count + CW'(1);
    end
    active_c = (next_c < CW'(ACTIVE));
    sync_c   = ((next_c >= CW'(SYNC_START)) && (next_c < CW'(SYNC_END))) ? POL : ~POL;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: counters, syncs, blanking, DE and line/frame strobes.
// Optional feature macro: VGA_TIMING_FRAME_CNT_EN adds a 16-bit frame_count output.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CW       = DEF_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_en,
  input  logic          restart,
  output logic [CW-1:0] h_count,
  output logic [CW-1:0] v_count,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          hblank,
  output logic          vblank,
  output logic          sol,
`ifdef VGA_TIMING_FRAME_CNT_EN
  output logic [15:0]   frame_count,
`endif
  output logic          sof
);

  logic [CW-1:0] h_count_q, h_count_d, v_count_q, v_count_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d;
  logic          de_q, de_d, hblank_q, hblank_d, vblank_q, vblank_d;
  logic          sol_q, sol_d, sof_q, sof_d;
  logic          started_q, started_d;
  logic          restart_go_c;
  logic          h_wrap_c, v_wrap_c, h_active_c, v_active_c, h_sync_c, v_sync_c;

  // First edge after reset behaves as a restart so the raster always opens at (0,0).
  assign restart_go_c = (pix_en && restart) || !started_q;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL), .CW(CW)
  ) u_h (
    .count(h_count_q), .advance(pix_en), .restart(restart_go_c),
    .next_c(h_count_d), .wrap_c(h_wrap_c), .active_c(h_active_c), .sync_c(h_sync_c)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL), .CW(CW)
  ) u_v (
    .count(v_count_q), .advance(h_wrap_c), .restart(restart_go_c),
    .next_c(v_count_d), .wrap_c(v_wrap_c), .active_c(v_active_c), .sync_c(v_sync_c)
  );

  // Output decode from next-state counts; strobes only fire when the count moves to 0.
  always_comb begin
    started_d = 1'b1;
    hsync_d   = h_sync_c;
    vsync_d   = v_sync_c;
    de_d      = h_active_c && v_active_c;
    hblank_d  = !h_active_c;
    vblank_d  = !v_active_c;
    sol_d     = restart_go_c || h_wrap_c;
    sof_d     = restart_go_c || (h_wrap_c && v_wrap_c);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_count_q <= '0;
      v_count_q <= '0;
      hsync_q   <= ~HS_POL;
      vsync_q   <= ~VS_POL;
      de_q      <= 1'b0;
      hblank_q  <= 1'b0;
      vblank_q  <= 1'b0;
      sol_q     <= 1'b0;
      sof_q     <= 1'b0;
      started_q <= 1'b0;
    end else begin
      h_count_q <= h_count_d;
      v_count_q <= v_count_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      de_q      <= de_d;
      hblank_q  <= hblank_d;
      vblank_q  <= vblank_d;
      sol_q     <= sol_d;
      sof_q     <= sof_d;
      started_q <= started_d;
    end
  end

  assign h_count = h_count_q;
  assign v_count = v_count_q;
  assign hsync   = hsync_q;
  assign vsync   = vsync_q;
  assign de      = de_q;
  assign hblank  = hblank_q;
  assign vblank  = vblank_q;
  assign sol     = sol_q;
  assign sof     = sof_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_count_q, frame_count_d;

  // Count only natural frame wraps; post-reset and restart openings are excluded.
  always_comb begin
    frame_count_d = frame_count_q;
    if (!restart_go_c && h_wrap_c && v_wrap_c) begin
      frame_count_d = frame_count_q + 16'(1);
    end
  end

  // Frame counter register; survives restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_count_q <= '0;
    end else begin
      frame_count_q <= frame_count_d;
    end
  end

  assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: default-mode and small-mode instances against an arithmetic raster model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_en = 1'b0;
  logic restart = 1'b0;

  logic [10:0] h0, v0;
  logic        hs0, vs0, de0, hb0, vb0, sol0, sof0;
  logic [3:0]  h1, v1;
  logic        hs1, vs1, de1, hb1, vb1, sol1, sof1;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] fc0, fc1;
`endif

  always #5 clk = ~clk;

  vga_timing_gen dut0 (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .restart(restart),
    .h_count(h0), .v_count(v0), .hsync(hs0), .vsync(vs0), .de(de0),
    .hblank(hb0), .vblank(vb0), .sol(sol0),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .frame_count(fc0),
`endif
    .sof(sof0)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .CW(4)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .restart(restart),
    .h_count(h1), .v_count(v1), .hsync(hs1), .vsync(vs1), .de(de1),
    .hblank(hb1), .vblank(vb1), .sol(sol1),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .frame_count(fc1),
`endif
    .sof(sof1)
  );

  // Mode table for the two instances.
  localparam int HA[2]  = '{640, 4};
  localparam int HF[2]  = '{16, 1};
  localparam int HS[2]  = '{96, 2};
  localparam int HB[2]  = '{48, 1};
  localparam int VA[2]  = '{480, 3};
  localparam int VF[2]  = '{10, 1};
  localparam int VS[2]  = '{2, 1};
  localparam int VB[2]  = '{33, 1};
  localparam int HPOL[2] = '{0, 1};
  localparam int VPOL[2] = '{0, 0};

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: raster position as a linear pixel index, plus strobes and frame count.
  int mh[2], mv[2], mfc[2], msol[2], msof[2];
  bit mst[2];

  function automatic void model_reset(input int id);
    mh[id] = 0; mv[id] = 0; mfc[id] = 0; msol[id] = 0; msof[id] = 0; mst[id] = 1'b0;
  endfunction

  function automatic void model_clk(input int id, input bit pe, input bit rs);
    int ht, vt, p;
    ht = HA[id] + HF[id] + HS[id] + HB[id];
    vt = VA[id] + VF[id] + VS[id] + VB[id];
    msol[id] = 0;
    msof[id] = 0;
    if (!mst[id] || (pe && rs)) begin
      mh[id] = 0; mv[id] = 0; msol[id] = 1; msof[id] = 1; mst[id] = 1'b1;
    end else if (pe) begin
      p = (mv[id] * ht + mh[id] + 1) % (ht * vt);
      mh[id] = p % ht;
      mv[id] = p / ht;
      msol[id] = (mh[id] == 0) ? 1 : 0;
      msof[id] = (p == 0) ? 1 : 0;
      if (p == 0) mfc[id] = (mfc[id] + 1) % 65536;
    end
  endfunction

  function automatic int in_win(input int pos, input int lo, input int w, input int pol);
    return ((pos >= lo) && (pos < lo + w)) ? pol : 1 - pol;
  endfunction

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_dut(input int id, input int h, input int v, input int hs, input int vs,
                           input int de, input int hb, input int vb, input int so, input int sf);
    string p;
    p = (id == 0) ? "d0" : "d1";
    chk({p, " h_count"}, h, mh[id]);
    chk({p, " v_count"}, v, mv[id]);
    chk({p, " hsync"}, hs, in_win(mh[id], HA[id] + HF[id], HS[id], HPOL[id]));
    chk({p, " vsync"}, vs, in_win(mv[id], VA[id] + VF[id], VS[id], VPOL[id]));
    chk({p, " de"}, de, (mst[id] && mh[id] < HA[id] && mv[id] < VA[id]) ? 1 : 0);
    chk({p, " hblank"}, hb, (mh[id] >= HA[id]) ? 1 : 0);
    chk({p, " vblank"}, vb, (mv[id] >= VA[id]) ? 1 : 0);
    chk({p, " sol"}, so, msol[id]);
    chk({p, " sof"}, sf, msof[id]);
  endtask

  task automatic check_all();
    check_dut(0, int'(h0), int'(v0), int'(hs0), int'(vs0), int'(de0), int'(hb0), int'(vb0),
              int'(sol0), int'(sof0));
    check_dut(1, int'(h1), int'(v1), int'(hs1), int'(vs1), int'(de1), int'(hb1), int'(vb1),
              int'(sol1), int'(sof1));
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("d0 frame_count", int'(fc0), mfc[0]);
    chk("d1 frame_count", int'(fc1), mfc[1]);
`endif
  endtask

  task automatic step(input bit pe, input bit rs);
    pix_en  = pe;
    restart = rs;
    @(posedge clk);
    #1;
    model_clk(0, pe, rs);
    model_clk(1, pe, rs);
    check_all();
  endtask

  initial begin
    model_reset(0);
    model_reset(1);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_all();

    // Release reset between edges; first edge opens at (0,0) even with pix_en low.
    #3 rst_n = 1'b1;
    step(1'b0, 1'b0);
    chk("post-reset de", int'(de0), 1);
    chk("post-reset sof", int'(sof0), 1);
    step(1'b0, 1'b0);
    chk("hold sof drop", int'(sof0), 0);

    // Continuous pixel rate: lines of the default mode, many frames of the small one.
    for (int i = 0; i < 2500; i++) step(1'b1, 1'b0);

    // Random enables with rare restarts.
    for (int i = 0; i < 2500; i++)
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 199) == 0));

    // One-in-four enable cadence.
    for (int i = 0; i < 800; i++) step((i % 4) == 3, 1'b0);

    // Restart with pix_en at h=300.
    for (int i = 0; i < 1000 && mh[0] != 300; i++) step(1'b1, 1'b0);
    chk("reach h300", int'(h0), 300);
    step(1'b1, 1'b1);
    chk("restart h", int'(h0), 0);
    chk("restart sof", int'(sof0), 1);
    chk("restart de", int'(de0), 1);
    for (int i = 0; i < 37; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    chk("ignored restart h", int'(h0), 37);

    // Async reset while the small mode sits inside both sync pulses.
    for (int i = 0; i < 200 && !(mh[1] == 5 && mv[1] == 4); i++) step(1'b1, 1'b0);
    chk("sync hs asserted", int'(hs1), 1);
    chk("sync vs asserted", int'(vs1), 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    check_all();
    #2 rst_n = 1'b1;
    step(1'b1, 1'b0);
    chk("rearm h", int'(h1), 0);
    chk("rearm sof", int'(sof1), 1);
    for (int i = 0; i < 200; i++) step(1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
